// File: rtl/uart_bus_pkg.sv
// Shared definitions for the UART bus master.
//   state_t         : bus-master FSM states
//   RD_* / WR_*     : bit positions within the one-hot read / write strobes
//   ST_*            : bit positions within the UART status byte
package uart_bus_pkg;

  typedef enum logic [2:0] {
    S_CFG,
    S_IDLE,
    S_STAT,
    S_RXRD,
    S_TXWR,
    S_HOLD
  } state_t;

  localparam int RD_DATA = 0;
  localparam int RD_STAT = 1;
  localparam int RD_SW   = 2;
  localparam int WR_TX   = 0;
  localparam int WR_CFG  = 6;

  localparam int ST_RXRDY = 0;
  localparam int ST_TXRDY = 1;
  localparam int ST_PERR  = 2;
  localparam int ST_FERR  = 3;
  localparam int ST_OVF   = 4;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous 8-bit FIFO holding bytes waiting to be echoed.
//   clk, reset : clock, synchronous active-high reset (flushes the FIFO)
//   push, din  : write din when not full
//   pop        : discard head when not empty
//   full, empty, count : occupancy
//   head       : oldest byte, valid whenever !empty
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             head
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Head must be visible in the cycle before the TX write is issued, so the
  // read port is asynchronous (tiny distributed memory).
  assign head = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

  // Power-of-two depth: pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (push_ok && !pop_ok)      count_reg <= count_reg + (AW+1)'(1);
      else if (pop_ok && !push_ok) count_reg <= count_reg - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_echo_master.sv
// Bus master standing in for the processor on the UART I/O port.
// Configures the UART, services its interrupt, reads status/RX data, buffers
// received bytes and, when echo_en is set, writes them back to TX data.
//   clk, reset     : clock, synchronous active-high reset
//   cfg, cfg_load  : UART config byte and reconfigure request pulse
//   echo_en        : enable echoing buffered bytes
//   interrupt      : UART interrupt; interrupt_ack clears it (1 cycle)
//   in_port        : UART read mux; out_port, read, write drive the bus
//   rx_byte, rx_strobe       : last received byte and its update pulse
//   err_count, drop_count    : saturating error / overflow-drop counters
//   busy           : FSM not in IDLE
module uart_echo_master
  import uart_bus_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       cfg,
  input  logic             cfg_load,
  input  logic             echo_en,
  input  logic             interrupt,
  input  logic [15:0]      in_port,
  output logic [15:0]      out_port,
  output logic [7:0]       read,
  output logic [7:0]       write,
  output logic             interrupt_ack,
  output logic [7:0]       rx_byte,
  output logic             rx_strobe,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             busy
);

  localparam int FC_W = $clog2(FIFO_DEPTH) + 1;

  state_t           state_reg, state_next;
  logic [7:0]       read_reg, read_next;
  logic [7:0]       write_reg, write_next;
  logic [15:0]      out_port_reg, out_port_next;
  logic             ack_reg, ack_next;
  logic             cfg_pend_reg;
  logic             err_flag_reg;
  logic [7:0]       rx_byte_reg;
  logic             rx_strobe_reg;
  logic [CNT_W-1:0] err_count_reg;
  logic [CNT_W-1:0] drop_count_reg;

  logic             fifo_full;
  logic             fifo_empty;
  logic [FC_W-1:0]  fifo_count;
  logic [7:0]       fifo_head;
  logic             echo_ready;
  logic             unused_bits;

  assign echo_ready  = !fifo_empty && echo_en;
  assign unused_bits = ^{in_port[15:8], fifo_count};

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (state_reg == S_RXRD),
    .pop   (state_reg == S_TXWR),
    .din   (in_port[7:0]),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_CFG;
    else       state_reg <= state_next;
  end

  // Next-state logic. Strobes are registered from the next state, so the
  // reset-entered CFG has no write yet: CFG holds until its strobe is out,
  // which makes the first post-reset cycle issue the config write.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_CFG:  if (write_reg[WR_CFG]) state_next = S_IDLE;
      S_IDLE: begin
        if (cfg_pend_reg)     state_next = S_CFG;
        else if (interrupt)   state_next = S_STAT;
        else if (echo_ready)  state_next = S_STAT;
      end
      S_STAT: begin
        if (in_port[ST_RXRDY])                     state_next = S_RXRD;
        else if (in_port[ST_TXRDY] && echo_ready)  state_next = S_TXWR;
        else                                       state_next = S_IDLE;
      end
      S_RXRD: state_next = S_STAT;   // re-poll: catches coalesced interrupts
      S_TXWR: state_next = S_HOLD;
      S_HOLD: state_next = S_IDLE;   // lets TxRdy fall before the next status read
      default: state_next = S_CFG;
    endcase
  end

  // Output decode from the next state.
  always_comb begin
    read_next     = '0;
    write_next    = '0;
    out_port_next = '0;
    ack_next      = 1'b0;
    case (state_next)
      S_CFG: begin
        write_next[WR_CFG] = 1'b1;
        out_port_next      = {8'h00, cfg};
      end
      S_STAT: begin
        read_next[RD_STAT] = 1'b1;
        ack_next           = (state_reg == S_IDLE) && interrupt;
      end
      S_RXRD: read_next[RD_DATA] = 1'b1;
      S_TXWR: begin
        write_next[WR_TX] = 1'b1;
        out_port_next     = {8'h00, fifo_head};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read_reg     <= '0;
      write_reg    <= '0;
      out_port_reg <= '0;
      ack_reg      <= 1'b0;
    end else begin
      read_reg     <= read_next;
      write_reg    <= write_next;
      out_port_reg <= out_port_next;
      ack_reg      <= ack_next;
    end
  end

  // Datapath: config request, RX capture, counters. rx_strobe rises together
  // with the new rx_byte value, i.e. the cycle after the data read.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_pend_reg   <= 1'b0;
      err_flag_reg   <= 1'b0;
      rx_byte_reg    <= '0;
      rx_strobe_reg  <= 1'b0;
      err_count_reg  <= '0;
      drop_count_reg <= '0;
    end else begin
      if (cfg_load)                                cfg_pend_reg <= 1'b1;
      else if (state_reg == S_IDLE && cfg_pend_reg) cfg_pend_reg <= 1'b0;

      if (state_reg == S_STAT)
        err_flag_reg <= in_port[ST_OVF] | in_port[ST_FERR] | in_port[ST_PERR];

      rx_strobe_reg <= (state_reg == S_RXRD);
      if (state_reg == S_RXRD) begin
        rx_byte_reg <= in_port[7:0];
        if (fifo_full && drop_count_reg != '1)
          drop_count_reg <= drop_count_reg + CNT_W'(1);
        if (err_flag_reg && err_count_reg != '1)
          err_count_reg <= err_count_reg + CNT_W'(1);
      end
    end
  end

  assign out_port      = out_port_reg;
  assign read          = read_reg;
  assign write         = write_reg;
  assign interrupt_ack = ack_reg;
  assign rx_byte       = rx_byte_reg;
  assign rx_strobe     = rx_strobe_reg;
  assign err_count     = err_count_reg;
  assign drop_count    = drop_count_reg;
  assign busy          = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_echo_master.sv
// Directed bench for uart_echo_master with a small UART register/interrupt model.
module tb_uart_echo_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  cfg = 8'h00;
  logic        cfg_load = 1'b0;
  logic        echo_en = 1'b0;
  logic        interrupt = 1'b0;
  logic [15:0] in_port;
  logic [15:0] out_port;
  logic [7:0]  read;
  logic [7:0]  write;
  logic        interrupt_ack;
  logic [7:0]  rx_byte;
  logic        rx_strobe;
  logic [7:0]  err_count;
  logic [7:0]  drop_count;
  logic        busy;

  uart_echo_master #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg           (cfg),
    .cfg_load      (cfg_load),
    .echo_en       (echo_en),
    .interrupt     (interrupt),
    .in_port       (in_port),
    .out_port      (out_port),
    .read          (read),
    .write         (write),
    .interrupt_ack (interrupt_ack),
    .rx_byte       (rx_byte),
    .rx_strobe     (rx_strobe),
    .err_count     (err_count),
    .drop_count    (drop_count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int rx_cnt  = 0;
  logic [7:0] tx_log [$];

  // UART model: queued RX entries {ovf,ferr,perr,data}; RS interrupt flop.
  logic [10:0] rx_q [$];
  logic [10:0] rx_ent;
  logic        rxrdy = 1'b0;
  logic        tx_ready = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic [2:0]  rx_flags = 3'b000;

  always @(posedge clk) begin
    if (interrupt_ack) interrupt <= 1'b0;
    if (read[0]) begin
      rxrdy    <= 1'b0;
      rx_flags <= 3'b000;
    end else if (!rxrdy && rx_q.size() != 0) begin
      rx_ent     = rx_q.pop_front();
      rx_data   <= rx_ent[7:0];
      rx_flags  <= rx_ent[10:8];
      rxrdy     <= 1'b1;
      interrupt <= 1'b1;
    end
  end

  assign in_port = read[0] ? {8'h00, rx_data} :
                   read[1] ? {8'h00, 3'b000, rx_flags, tx_ready, rxrdy} : 16'h0000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, got);
    end
  endtask

  // Bus monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (|{read, write}) check_eq("strobe_onehot", $countones({read, write}), 1);
    if (write[0]) tx_log.push_back(out_port[7:0]);
    if (rx_strobe) rx_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam int C_ACK = 0, C_RDDATA = 1, C_TXWR = 2, C_CFGWR = 3;

  function automatic bit cond(input int sel);
    case (sel)
      C_ACK:    return interrupt_ack;
      C_RDDATA: return read == 8'h01;
      C_TXWR:   return write == 8'h01;
      C_CFGWR:  return write == 8'h40;
      default:  return 1'b0;
    endcase
  endfunction

  task automatic wait_cond(input int sel, input int limit, input string tag);
    int n = 0;
    while (!cond(sel) && n < limit) begin
      tick();
      n++;
    end
    if (!cond(sel)) check_eq({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_rx(input int target, input int limit, input string tag);
    int n = 0;
    while (rx_cnt < target && n < limit) begin
      tick();
      n++;
    end
    check_eq({tag, "_rxcount"}, rx_cnt, target);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    bit prev_busy;
    int n;

    // 1. Reset and initial config write
    cfg = 8'hB8;
    repeat (3) tick();
    check_eq("rst_write", write, 8'h00);
    check_eq("rst_read", read, 8'h00);
    check_eq("rst_out_port", out_port, 16'h0000);
    check_eq("rst_ack", interrupt_ack, 1'b0);
    check_eq("rst_rx_strobe", rx_strobe, 1'b0);
    check_eq("rst_rx_byte", rx_byte, 8'h00);
    check_eq("rst_err", err_count, 8'h00);
    check_eq("rst_drop", drop_count, 8'h00);
    check_eq("rst_busy", busy, 1'b1);
    reset = 1'b0;
    tick();
    check_eq("cfg_write", write, 8'h40);
    check_eq("cfg_out_port", out_port, 16'h00B8);
    tick();
    check_eq("cfg_write_end", write, 8'h00);
    check_eq("cfg_busy", busy, 1'b0);

    // 2. Interrupt-driven receive and echo
    echo_en  = 1'b1;
    tx_ready = 1'b1;
    rx_q.push_back({3'b000, 8'hA5});
    wait_cond(C_ACK, 20, "t2_ack");
    check_eq("t2_stat_read", read, 8'h02);
    tick();
    check_eq("t2_ack_end", interrupt_ack, 1'b0);
    check_eq("t2_data_read", read, 8'h01);
    tick();
    check_eq("t2_rx_strobe", rx_strobe, 1'b1);
    check_eq("t2_rx_byte", rx_byte, 8'hA5);
    check_eq("t2_repoll", read, 8'h02);
    tick();
    check_eq("t2_tx_write", write, 8'h01);
    check_eq("t2_tx_data", out_port, 16'h00A5);
    tick();
    check_eq("t2_hold", write, 8'h00);

    // 3. Framing error counted, byte still echoed
    tx_ready = 1'b0;
    base = rx_cnt;
    rx_q.push_back({3'b010, 8'h3C});
    wait_rx(base + 1, 50, "t3");
    check_eq("t3_rx_byte", rx_byte, 8'h3C);
    check_eq("t3_err", err_count, 8'h01);
    check_eq("t3_drop", drop_count, 8'h00);
    tx_ready = 1'b1;
    wait_cond(C_TXWR, 30, "t3_tx");
    check_eq("t3_tx_data", out_port, 16'h003C);

    // 4. FIFO overflow: five bytes with TX blocked
    repeat (5) tick();
    tx_ready = 1'b0;
    base = rx_cnt;
    for (int i = 0; i < 5; i++) rx_q.push_back({3'b000, 8'h11 + 8'(i)});
    wait_rx(base + 5, 200, "t4");
    check_eq("t4_drop", drop_count, 8'h01);
    check_eq("t4_err", err_count, 8'h01);
    check_eq("t4_last_rx", rx_byte, 8'h15);
    tx_log.delete();
    tx_ready = 1'b1;
    repeat (40) tick();
    check_eq("t4_tx_count", tx_log.size(), 4);
    for (int i = 0; i < 4; i++)
      check_eq("t4_tx_order", (i < tx_log.size()) ? 32'(tx_log[i]) : 32'hFFFF, 8'h11 + 8'(i));

    // 5. Reset during a TX write flushes the FIFO
    tx_ready = 1'b0;
    base = rx_cnt;
    rx_q.push_back({3'b000, 8'h21});
    rx_q.push_back({3'b000, 8'h22});
    wait_rx(base + 2, 100, "t5");
    tx_ready = 1'b1;
    wait_cond(C_TXWR, 30, "t5_tx");
    reset = 1'b1;
    tick();
    check_eq("t5_rst_write", write, 8'h00);
    check_eq("t5_rst_busy", busy, 1'b1);
    tick();
    reset = 1'b0;
    cfg = 8'h5A;
    tick();
    check_eq("t5_cfg_write", write, 8'h40);
    check_eq("t5_cfg_data", out_port, 16'h005A);
    check_eq("t5_drop_clr", drop_count, 8'h00);
    tx_log.delete();
    repeat (30) tick();
    check_eq("t5_no_stale_tx", tx_log.size(), 0);

    // 6. Echo disabled, reconfigure requested mid-receive
    echo_en = 1'b0;
    cfg = 8'hC4;
    tx_log.delete();
    base = rx_cnt;
    rx_q.push_back({3'b000, 8'h31});
    rx_q.push_back({3'b000, 8'h32});
    wait_cond(C_RDDATA, 50, "t6_rd");
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    prev_busy = busy;
    n = 0;
    while (write != 8'h40 && n < 50) begin
      prev_busy = busy;
      tick();
      n++;
    end
    check_eq("t6_cfg_write", write, 8'h40);
    check_eq("t6_cfg_from_idle", prev_busy, 1'b0);
    check_eq("t6_cfg_data", out_port, 16'h00C4);
    wait_rx(base + 2, 100, "t6");
    repeat (20) tick();
    check_eq("t6_no_tx", tx_log.size(), 0);
    echo_en = 1'b1;
    repeat (40) tick();
    check_eq("t6_drain_count", tx_log.size(), 2);
    check_eq("t6_drain_0", (tx_log.size() > 0) ? 32'(tx_log[0]) : 32'hFFFF, 8'h31);
    check_eq("t6_drain_1", (tx_log.size() > 1) ? 32'(tx_log[1]) : 32'hFFFF, 8'h32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
